// File: rtl/pw_lock_pkg.sv
// Shared types and constants for the serial password lock controller.
// The state enum, digit/address widths and the legal-digit test live here.
package pw_lock_pkg;

   localparam int DIGIT_W = 4;
   localparam int ADDR_W  = 2;
   localparam int PW_LEN  = 4;
   localparam logic [DIGIT_W-1:0] MAX_DIGIT = 4'd9;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SET,
      ST_CHECK,
      ST_UNLOCKED,
      ST_ALARM
   } state_t;

   // Keys above 9 are keypad function keys; their strobes are dropped entirely.
   function automatic logic is_legal(input logic valid, input logic [DIGIT_W-1:0] d);
      return valid && (d <= MAX_DIGIT);
   endfunction

endpackage

// File: rtl/entry_timer.sv
// Idle-cycle counter for an entry in progress: counts cycles while run is high,
// restarts on a key press and pulses expired on the TIMEOUT_CYCLES-th idle cycle.
module entry_timer #(
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic CLK,
   input  logic RST,
   input  logic run,
   input  logic restart,
   output logic expired
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] r_count;
   logic             w_expired;

   // A press in the expiry cycle wins, so restart masks the pulse.
   assign w_expired = run && !restart && (r_count == LAST_CNT);
   assign expired   = w_expired;

   always_ff @(posedge CLK) begin
      if (RST || !run || restart || w_expired) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/password_controller.sv
// Serial password lock FSM: programs or checks a 4-digit password held in an
// external 4x4 store, and tracks unlock state, consecutive failures and lockout.
module password_controller #(
   parameter int PW_LEN         = 4,
   parameter int MAX_FAILS      = 3,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                            CLK,
   input  logic                            RST,
   input  logic                            digit_valid,
   input  logic [pw_lock_pkg::DIGIT_W-1:0] digit,
   input  logic                            mode_set,
   input  logic                            clear,
   output logic [pw_lock_pkg::ADDR_W-1:0]  store_addr,
   output logic                            store_write,
   output logic [pw_lock_pkg::DIGIT_W-1:0] store_wdata,
   input  logic [pw_lock_pkg::DIGIT_W-1:0] store_rdata,
   output logic                            unlocked,
   output logic                            err,
   output logic                            set_done,
   output logic                            alarm,
   output logic [2:0]                      fail_count,
   output logic                            pw_valid
);

   import pw_lock_pkg::*;

   localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(PW_LEN - 1);
   localparam logic [2:0]        FAIL_LIMIT = 3'(MAX_FAILS);

   state_t            r_state;
   logic [ADDR_W-1:0] r_idx;
   logic              r_mismatch;
   logic [2:0]        r_fail;
   logic              r_pw_valid;
   logic              r_err;
   logic              r_set_done;

   state_t            w_state_next;
   logic [ADDR_W-1:0] w_idx_next;
   logic              w_mismatch_next;
   logic [2:0]        w_fail_next;
   logic              w_pw_valid_next;
   logic              w_err_next;
   logic              w_set_done_next;
   logic              w_write;

   logic              w_legal;
   logic              w_ne;
   logic [2:0]        w_fail_inc;
   logic              w_run;
   logic              w_expired;

   assign w_legal    = is_legal(digit_valid, digit);
   assign w_ne       = (digit != store_rdata);
   assign w_fail_inc = r_fail + 3'd1;
   assign w_run      = (r_state == ST_SET) || (r_state == ST_CHECK);

   entry_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_entry_timer (
      .CLK    (CLK),
      .RST    (RST),
      .run    (w_run),
      .restart(w_legal),
      .expired(w_expired)
   );

   always_comb begin
      w_state_next    = r_state;
      w_idx_next      = r_idx;
      w_mismatch_next = r_mismatch;
      w_fail_next     = r_fail;
      w_pw_valid_next = r_pw_valid;
      w_err_next      = 1'b0;
      w_set_done_next = 1'b0;
      w_write         = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (w_legal) begin
               if (mode_set && !r_pw_valid) begin
                  w_write         = 1'b1;
                  w_idx_next      = r_idx + ADDR_W'(1);
                  w_mismatch_next = 1'b0;
                  w_state_next    = ST_SET;
               end else if (!mode_set && r_pw_valid) begin
                  w_mismatch_next = w_ne;
                  w_idx_next      = r_idx + ADDR_W'(1);
                  w_state_next    = ST_CHECK;
               end else begin
                  // Reprogram while locked, or check with nothing programmed.
                  w_err_next = 1'b1;
               end
            end
         end

         ST_SET: begin
            if (w_legal) begin
               w_write = 1'b1;
               if (r_idx == LAST_IDX) begin
                  w_pw_valid_next = 1'b1;
                  w_set_done_next = 1'b1;
                  w_idx_next      = '0;
                  w_state_next    = ST_IDLE;
               end else begin
                  w_idx_next = r_idx + ADDR_W'(1);
               end
            end else if (w_expired) begin
               w_err_next      = 1'b1;
               w_idx_next      = '0;
               w_mismatch_next = 1'b0;
               w_state_next    = ST_IDLE;
            end
         end

         ST_CHECK: begin
            if (w_legal) begin
               if (r_idx == LAST_IDX) begin
                  w_idx_next      = '0;
                  w_mismatch_next = 1'b0;
                  if (!(r_mismatch || w_ne)) begin
                     w_fail_next  = '0;
                     w_state_next = ST_UNLOCKED;
                  end else begin
                     w_fail_next  = w_fail_inc;
                     w_err_next   = 1'b1;
                     w_state_next = (w_fail_inc >= FAIL_LIMIT) ? ST_ALARM : ST_IDLE;
                  end
               end else begin
                  w_mismatch_next = r_mismatch || w_ne;
                  w_idx_next      = r_idx + ADDR_W'(1);
               end
            end else if (w_expired) begin
               w_err_next      = 1'b1;
               w_idx_next      = '0;
               w_mismatch_next = 1'b0;
               w_state_next    = ST_IDLE;
            end
         end

         ST_UNLOCKED: begin
            if (clear) begin
               w_state_next = ST_IDLE;
            end else if (w_legal && mode_set) begin
               w_write         = 1'b1;
               w_idx_next      = r_idx + ADDR_W'(1);
               w_mismatch_next = 1'b0;
               w_state_next    = ST_SET;
            end
         end

         ST_ALARM: begin
            w_state_next = ST_ALARM;
         end

         default: begin
            w_state_next = ST_IDLE;
            w_idx_next   = '0;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state    <= ST_IDLE;
         r_idx      <= '0;
         r_mismatch <= 1'b0;
         r_fail     <= '0;
         r_pw_valid <= 1'b0;
         r_err      <= 1'b0;
         r_set_done <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_idx      <= w_idx_next;
         r_mismatch <= w_mismatch_next;
         r_fail     <= w_fail_next;
         r_pw_valid <= w_pw_valid_next;
         r_err      <= w_err_next;
         r_set_done <= w_set_done_next;
      end
   end

   // A reset cycle must never disturb the store, even mid-program.
   assign store_write = w_write && !RST;
   assign store_addr  = r_idx;
   assign store_wdata = digit;
   assign unlocked    = (r_state == ST_UNLOCKED);
   assign alarm       = (r_state == ST_ALARM);
   assign err         = r_err;
   assign set_done    = r_set_done;
   assign fail_count  = r_fail;
   assign pw_valid    = r_pw_valid;

endmodule

// File: tb/tb_password_controller.sv
// Bench for password_controller: vector table, directed corner sequences and
// random traffic, all compared against an entry-level reference model.
module tb_password_controller;

   localparam int T    = 40;
   localparam int MAXF = 3;
   localparam int M_IDLE = 0, M_SET = 1, M_CHECK = 2, M_UNL = 3, M_ALARM = 4;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       digit_valid = 1'b0;
   logic [3:0] digit = 4'd0;
   logic       mode_set = 1'b0;
   logic       clear = 1'b0;
   logic [1:0] store_addr;
   logic       store_write;
   logic [3:0] store_wdata;
   logic [3:0] store_rdata;
   logic       unlocked, err, set_done, alarm, pw_valid;
   logic [2:0] fail_count;

   logic [3:0] tb_mem [4] = '{default: 4'd0};

   int checks = 0;
   int errors = 0;

   // Reference model: tracks the entry as a list of digits and judges it whole.
   int m_phase = M_IDLE;
   int m_entry[$];
   int m_idle  = 0;
   int m_fails = 0;
   bit m_pwv   = 1'b0;
   int m_mem[4] = '{default: 0};
   bit m_err   = 1'b0;
   bit m_sd    = 1'b0;

   bit s_write;
   int s_addr;

   typedef struct {
      bit dv; int d; bit ms; bit clr;
      bit w; int a; bit unl; bit er; bit sd; bit al; int fc; bit pv;
   } vec_t;
   vec_t tbl[$];

   always #5 CLK = ~CLK;

   password_controller #(
      .PW_LEN(4), .MAX_FAILS(MAXF), .TIMEOUT_CYCLES(T)
   ) dut (
      .CLK(CLK), .RST(RST), .digit_valid(digit_valid), .digit(digit),
      .mode_set(mode_set), .clear(clear), .store_addr(store_addr),
      .store_write(store_write), .store_wdata(store_wdata), .store_rdata(store_rdata),
      .unlocked(unlocked), .err(err), .set_done(set_done), .alarm(alarm),
      .fail_count(fail_count), .pw_valid(pw_valid)
   );

   always @(posedge CLK) if (store_write) tb_mem[store_addr] <= store_wdata;
   assign store_rdata = tb_mem[store_addr];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int m_addr();
      return (m_phase == M_SET || m_phase == M_CHECK) ? m_entry.size() : 0;
   endfunction

   function automatic bit m_write(bit rst, bit dv, int d, bit ms, bit clr);
      if (rst || !(dv && d <= 9)) return 1'b0;
      case (m_phase)
         M_IDLE:  return ms && !m_pwv;
         M_SET:   return 1'b1;
         M_UNL:   return ms && !clr;
         default: return 1'b0;
      endcase
   endfunction

   task automatic m_start(input int kind, input int d);
      m_entry.delete();
      if (kind == M_SET) m_mem[0] = d;
      m_entry.push_back(d);
      m_phase = kind;
      m_idle  = 0;
   endtask

   task automatic m_finish();
      bit ok = 1'b1;
      if (m_phase == M_SET) begin
         m_pwv = 1'b1; m_sd = 1'b1; m_phase = M_IDLE;
      end else begin
         foreach (m_entry[i]) if (m_entry[i] != m_mem[i]) ok = 1'b0;
         if (ok) begin
            m_phase = M_UNL; m_fails = 0;
         end else begin
            m_fails++; m_err = 1'b1;
            m_phase = (m_fails >= MAXF) ? M_ALARM : M_IDLE;
         end
      end
      m_entry.delete();
   endtask

   task automatic m_tick(input bit rst, input bit dv, input int d, input bit ms, input bit clr);
      bit lg = dv && (d <= 9);
      m_err = 1'b0; m_sd = 1'b0;
      if (rst) begin
         m_phase = M_IDLE; m_entry.delete(); m_idle = 0; m_fails = 0; m_pwv = 1'b0;
         return;
      end
      case (m_phase)
         M_IDLE: if (lg) begin
            if (ms && !m_pwv) m_start(M_SET, d);
            else if (!ms && m_pwv) m_start(M_CHECK, d);
            else m_err = 1'b1;
         end
         M_SET, M_CHECK: if (lg) begin
            if (m_phase == M_SET) m_mem[m_entry.size()] = d;
            m_entry.push_back(d);
            m_idle = 0;
            if (m_entry.size() == 4) m_finish();
         end else begin
            m_idle++;
            if (m_idle == T) begin
               m_err = 1'b1; m_entry.delete(); m_phase = M_IDLE;
            end
         end
         M_UNL: begin
            if (clr) m_phase = M_IDLE;
            else if (lg && ms) m_start(M_SET, d);
         end
         default: ;
      endcase
   endtask

   // One clock: drive after negedge, check combinational store pins, clock, check registered outputs.
   task automatic step(input bit rst, input bit dv, input int d, input bit ms, input bit clr);
      bit ew;
      int ea;
      RST = rst; digit_valid = dv; digit = 4'(d); mode_set = ms; clear = clr;
      #1;
      ew = m_write(rst, dv, d, ms, clr);
      ea = m_addr();
      s_write = store_write;
      s_addr  = store_addr;
      chk("store_write", store_write, ew);
      chk("store_addr", store_addr, ea);
      if (ew) chk("store_wdata", store_wdata, d);
      m_tick(rst, dv, d, ms, clr);
      @(posedge CLK);
      #1;
      $display("t=%0t rst=%0b dv=%0b d=%0d ms=%0b clr=%0b -> unl=%0b err=%0b sd=%0b al=%0b fc=%0d pv=%0b",
               $time, rst, dv, d, ms, clr, unlocked, err, set_done, alarm, fail_count, pw_valid);
      chk("unlocked", unlocked, m_phase == M_UNL);
      chk("err", err, m_err);
      chk("set_done", set_done, m_sd);
      chk("alarm", alarm, m_phase == M_ALARM);
      chk("fail_count", fail_count, m_fails);
      chk("pw_valid", pw_valid, m_pwv);
      @(negedge CLK);
   endtask

   function automatic void add(bit dv, int d, bit ms, bit clr, bit w, int a,
                               bit unl, bit er, bit sd, bit al, int fc, bit pv);
      vec_t v;
      v.dv = dv; v.d = d; v.ms = ms; v.clr = clr; v.w = w; v.a = a;
      v.unl = unl; v.er = er; v.sd = sd; v.al = al; v.fc = fc; v.pv = pv;
      tbl.push_back(v);
   endfunction

   initial begin
      int chk_digits[4];
      int dvp;
      bit r_rst, r_dv, r_ms, r_clr;
      int r_d;

      // Program 1,2,3,4 from reset
      add(1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      add(1, 2, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
      add(1, 3, 1, 0, 1, 2, 0, 0, 0, 0, 0, 0);
      add(1, 4, 1, 0, 1, 3, 0, 0, 1, 0, 0, 1);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      // Correct check, then relock
      add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      add(1, 2, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
      add(1, 3, 0, 0, 0, 2, 0, 0, 0, 0, 0, 1);
      add(1, 4, 0, 0, 0, 3, 1, 0, 0, 0, 0, 1);
      add(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
      add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
      // Three wrong checks lead to alarm
      chk_digits = '{1, 2, 9, 4};
      for (int k = 1; k <= 3; k++) begin
         for (int j = 0; j < 3; j++) add(1, chk_digits[j], 0, 0, 0, j, 0, 0, 0, 0, k - 1, 1);
         add(1, 4, 0, 0, 0, 3, 0, 1, 0, k == 3, k, 1);
         add(0, 0, 0, 0, 0, 0, 0, 0, 0, k == 3, k, 1);
      end
      // Alarm ignores a correct entry, a program attempt and clear
      for (int j = 1; j <= 4; j++) add(1, j, 0, 0, 0, 0, 0, 0, 0, 1, 3, 1);
      add(1, 5, 1, 1, 0, 0, 0, 0, 0, 1, 3, 1);

      @(negedge CLK);
      step(1, 0, 0, 0, 0);
      chk("reset_unlocked", unlocked, 0);
      chk("reset_pw_valid", pw_valid, 0);
      chk("reset_addr", store_addr, 0);

      foreach (tbl[i]) begin
         step(0, tbl[i].dv, tbl[i].d, tbl[i].ms, tbl[i].clr);
         chk($sformatf("v%0d_write", i), s_write, tbl[i].w);
         chk($sformatf("v%0d_addr", i), s_addr, tbl[i].a);
         chk($sformatf("v%0d_unlocked", i), unlocked, tbl[i].unl);
         chk($sformatf("v%0d_err", i), err, tbl[i].er);
         chk($sformatf("v%0d_set_done", i), set_done, tbl[i].sd);
         chk($sformatf("v%0d_alarm", i), alarm, tbl[i].al);
         chk($sformatf("v%0d_fail_count", i), fail_count, tbl[i].fc);
         chk($sformatf("v%0d_pw_valid", i), pw_valid, tbl[i].pv);
      end

      // Reset leaves alarm
      step(1, 0, 0, 0, 0);
      chk("alarm_rst_alarm", alarm, 0);
      chk("alarm_rst_fail", fail_count, 0);
      chk("alarm_rst_pwv", pw_valid, 0);
      for (int j = 1; j <= 4; j++) step(0, 1, j, 1, 0);
      chk("reprog_pwv", pw_valid, 1);

      // Timeout mid-check leaves fail_count alone
      step(0, 1, 1, 0, 0); step(0, 1, 2, 0, 0); step(0, 1, 9, 0, 0); step(0, 1, 4, 0, 0);
      chk("pre_to_fail", fail_count, 1);
      step(0, 1, 1, 0, 0); step(0, 1, 2, 0, 0);
      for (int i = 0; i < T - 1; i++) step(0, 0, 0, 0, 0);
      chk("to_not_yet", err, 0);
      step(0, 0, 0, 0, 0);
      chk("to_err", err, 1);
      chk("to_fail_kept", fail_count, 1);
      step(0, 0, 0, 0, 0);
      chk("to_idx_reset", s_addr, 0);
      for (int j = 1; j <= 4; j++) step(0, 1, j, 0, 0);
      chk("to_then_unlock", unlocked, 1);
      chk("to_then_fail0", fail_count, 0);
      step(0, 0, 0, 0, 1);

      // Refused reprogram while locked; illegal key mid-entry
      step(0, 1, 5, 1, 0);
      chk("refuse_write", s_write, 0);
      chk("refuse_err", err, 1);
      step(0, 1, 1, 0, 0);
      step(0, 1, 12, 0, 0);
      step(0, 1, 2, 0, 0);
      chk("illegal_idx_kept", s_addr, 1);
      step(0, 1, 3, 0, 0); step(0, 1, 4, 0, 0);
      chk("illegal_unlock", unlocked, 1);

      // Clear beats a same-cycle program digit
      step(0, 1, 7, 1, 1);
      chk("clr_no_write", s_write, 0);
      chk("clr_unlocked", unlocked, 0);
      chk("clr_mem0", tb_mem[0], 1);

      // A key in the expiry cycle wins over the timeout
      step(0, 1, 1, 0, 0);
      for (int i = 0; i < T - 1; i++) step(0, 0, 0, 0, 0);
      step(0, 1, 2, 0, 0);
      chk("dw_err", err, 0);
      for (int i = 0; i < T - 1; i++) step(0, 0, 0, 0, 0);
      step(0, 1, 3, 0, 0); step(0, 1, 4, 0, 0);
      chk("dw_unlock", unlocked, 1);

      // Reset in the middle of a program entry
      step(1, 0, 0, 0, 0);
      step(0, 1, 1, 1, 0); step(0, 1, 2, 1, 0);
      step(1, 1, 6, 1, 0);
      chk("rst_set_write", s_write, 0);
      chk("rst_set_pwv", pw_valid, 0);
      chk("rst_set_unl", unlocked, 0);
      chk("rst_set_mem2", tb_mem[2], 3);

      // Random traffic against the model
      dvp = 60;
      for (int n = 0; n < 3000; n++) begin
         if (n % 50 == 0) dvp = ($urandom % 3 == 0) ? 3 : 60;
         r_rst = ($urandom % 200) == 0;
         r_dv  = ($urandom % 100) < dvp;
         r_d   = ($urandom % 2 == 1) ? m_mem[m_addr()] : int'($urandom_range(0, 15));
         r_ms  = ($urandom % 4) == 0;
         r_clr = ($urandom % 8) == 0;
         step(r_rst, r_dv, r_d, r_ms, r_clr);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
